shake256_squeeze_serializer: RTL and testbench

//  Downstream stage of the SHAKE256 core: turns the core's parallel rate-block output into a byte stream.

---
 rtl/shake256_squeeze_serializer.sv | 110 +++++++++++
 tb/tb_shake256_squeeze_serializer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shake256_squeeze_serializer.sv
// Byte serializer for the SHAKE256 squeeze phase: captures rate blocks from the
// core and streams them out little-endian over a valid/ready handshake.
module shake256_squeeze_serializer #(
  parameter int RATE_BITS = 1088,
  parameter int LEN_W     = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [LEN_W-1:0]     out_bytes,
  input  logic                 squeezed,
  input  logic [RATE_BITS-1:0] hash,
  output logic                 req_block,
  output logic [7:0]           out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done
);

  localparam int         NBYTES   = RATE_BITS / 8;
  localparam logic [7:0] LAST_IDX = 8'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, STREAM} state_t;

  state_t               state;
  logic                 sq_q;
  logic [RATE_BITS-1:0] blk_buf;
  logic [LEN_W-1:0]     remaining;
  logic [7:0]           byte_idx;
  logic                 capture;

  assign capture = squeezed & ~sq_q;

  // blk_buf[7:0] always mirrors the byte currently presented on out_data
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sq_q      <= 1'b0;
      blk_buf   <= '0;
      remaining <= '0;
      byte_idx  <= '0;
      req_block <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      sq_q      <= squeezed;
      req_block <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (out_bytes != '0) begin
              remaining <= out_bytes;
              req_block <= 1'b1;
              busy      <= 1'b1;
              state     <= WAIT;
            end else begin
              done <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (capture) begin
            blk_buf   <= hash;
            byte_idx  <= '0;
            out_data  <= hash[7:0];
            out_valid <= 1'b1;
            out_last  <= (remaining == LEN_W'(1));
            state     <= STREAM;
          end
        end
        STREAM: begin
          if (out_ready) begin
            blk_buf   <= blk_buf >> 8;
            remaining <= remaining - LEN_W'(1);
            byte_idx  <= byte_idx + 8'd1;
            // End of run takes priority over block exhaustion: no extra request
            if (remaining == LEN_W'(1)) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_data  <= '0;
              done      <= 1'b1;
              busy      <= 1'b0;
              state     <= IDLE;
            end else if (byte_idx == LAST_IDX) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              req_block <= 1'b1;
              state     <= WAIT;
            end else begin
              out_data <= blk_buf[15:8];
              out_last <= (remaining == LEN_W'(2));
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shake256_squeeze_serializer.sv
// Scoreboard bench for shake256_squeeze_serializer: a core model supplies random
// rate blocks and pushes the byte stream it implies; a monitor pops on each handshake.
module tb_shake256_squeeze_serializer;

  localparam int RATE_BITS = 1088;
  localparam int LEN_W     = 16;
  localparam int NBYTES    = RATE_BITS / 8;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 start;
  logic [LEN_W-1:0]     out_bytes;
  logic                 squeezed;
  logic [RATE_BITS-1:0] hash;
  logic                 req_block;
  logic [7:0]           out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_last;
  logic                 busy;
  logic                 done;

  shake256_squeeze_serializer #(.RATE_BITS(RATE_BITS), .LEN_W(LEN_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .out_bytes (out_bytes),
    .squeezed  (squeezed),
    .hash      (hash),
    .req_block (req_block),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          errors = 0;
  logic [8:0]  exp_q[$];
  int          model_rem  = 0;
  int          run_id     = 0;
  int          req_cnt    = 0;
  int          ready_mode = 0;
  int          spur_pct   = 2;
  logic [31:0] low_word   = '0;
  bit          use_low    = 1'b0;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Core model: answers each req_block with a random block after a random latency,
  // and occasionally raises squeezed when nothing was asked for.
  initial begin
    int my_run;
    int lat;
    int n;
    bit spur_hi;
    squeezed = 1'b0;
    hash     = '0;
    spur_hi  = 1'b0;
    forever begin
      @(negedge clock);
      if (spur_hi) begin
        squeezed = 1'b0;
        spur_hi  = 1'b0;
      end
      if (!reset && req_block) begin
        my_run = run_id;
        lat    = $urandom_range(1, 4);
        repeat (lat) @(negedge clock);
        if (!reset && my_run == run_id) begin
          for (int w = 0; w < RATE_BITS / 32; w++) hash[w*32 +: 32] = $urandom;
          if (use_low) begin
            hash[31:0] = low_word;
            use_low    = 1'b0;
          end
          n = (model_rem < NBYTES) ? model_rem : NBYTES;
          for (int k = 0; k < n; k++)
            exp_q.push_back({(k == n - 1) && (n == model_rem), hash[8*k +: 8]});
          model_rem -= n;
          squeezed = 1'b1;
          @(negedge clock);
          squeezed = 1'b0;
          if (!reset) check_output("first_byte_latency", out_valid, 1);
        end
      end else if (($urandom % 100) < spur_pct) begin
        for (int w = 0; w < RATE_BITS / 32; w++) hash[w*32 +: 32] = $urandom;
        squeezed = 1'b1;
        spur_hi  = 1'b1;
      end
    end
  end

  // Consumer ready pattern, changed just after each rising edge
  initial begin
    int ph;
    ph        = 0;
    out_ready = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom % 3) != 0;
        default: out_ready = (ph % 4 == 0) || (ph % 4 == 3);
      endcase
      ph++;
    end
  end

  // Monitor: pops expected bytes on handshakes, checks stall stability and req spacing
  logic       stalled  = 1'b0;
  logic       prev_req = 1'b0;
  logic [7:0] hold_data;
  logic       hold_last;
  always @(negedge clock) begin
    logic [8:0] e;
    if (reset) begin
      stalled  = 1'b0;
      prev_req = 1'b0;
    end else begin
      if (prev_req) check_output("req_not_consecutive", req_block, 0);
      if (req_block) req_cnt++;
      if (stalled) begin
        check_output("stall_valid", out_valid, 1);
        check_output("stall_data", out_data, hold_data);
        check_output("stall_last", out_last, hold_last);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_byte: got %0h, expected no byte", out_data);
        end else begin
          e = exp_q.pop_front();
          check_output("byte_data", out_data, e[7:0]);
          check_output("byte_last", out_last, e[8]);
        end
      end
      stalled   = out_valid && !out_ready;
      hold_data = out_data;
      hold_last = out_last;
      prev_req  = req_block;
    end
  end

  task automatic run_squeeze(input int len, input int mode);
    int cycles;
    int budget;
    ready_mode = mode;
    req_cnt    = 0;
    model_rem  = len;
    run_id++;
    @(negedge clock);
    start     = 1'b1;
    out_bytes = LEN_W'(len);
    @(negedge clock);
    start = 1'b0;
    if (len == 0) begin
      check_output("zero_len_done", done, 1);
      check_output("zero_len_valid", out_valid, 0);
      check_output("zero_len_req", req_block, 0);
      check_output("zero_len_busy", busy, 0);
    end else begin
      check_output("start_req", req_block, 1);
      check_output("start_busy", busy, 1);
      cycles = 0;
      budget = 20 * len + 500;
      while (!done && cycles < budget) begin
        @(negedge clock);
        cycles++;
      end
      if (!done) begin
        checks++;
        errors++;
        $display("[TB] FAIL done_timeout: got no done after %0d cycles, expected done for len %0d", cycles, len);
      end else begin
        check_output("all_bytes_out", exp_q.size(), 0);
        check_output("req_count", req_cnt, (len + NBYTES - 1) / NBYTES);
        check_output("done_valid_low", out_valid, 0);
        check_output("done_busy_low", busy, 0);
      end
    end
    @(negedge clock);
    check_output("done_one_cycle", done, 0);
  endtask

  task automatic apply_stimulus();
    int cycles;
    // Reset state
    reset     = 1'b1;
    start     = 1'b0;
    out_bytes = '0;
    repeat (3) @(negedge clock);
    check_output("rst_valid", out_valid, 0);
    check_output("rst_data", out_data, 0);
    check_output("rst_last", out_last, 0);
    check_output("rst_req", req_block, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_done", done, 0);
    reset = 1'b0;

    // Zero-length request, then squeezed edges while idle must be ignored
    run_squeeze(0, 0);
    spur_pct = 50;
    cycles   = 0;
    repeat (30) begin
      @(negedge clock);
      if (out_valid || busy || req_block) cycles++;
    end
    check_output("idle_ignores_squeeze", cycles, 0);
    spur_pct = 2;

    low_word = 32'hDDCCBBAA;
    use_low  = 1'b1;
    run_squeeze(4, 0);
    run_squeeze(136, 0);
    run_squeeze(140, 0);
    run_squeeze(20, 2);
    run_squeeze(272, 1);

    // Reset in the middle of a stream aborts without done
    ready_mode = 0;
    model_rem  = 300;
    run_id++;
    @(negedge clock);
    start     = 1'b1;
    out_bytes = LEN_W'(300);
    @(negedge clock);
    start  = 1'b0;
    cycles = 0;
    while (!out_valid && cycles < 50) begin
      @(negedge clock);
      cycles++;
    end
    check_output("stream_started", out_valid, 1);
    repeat (5) @(negedge clock);
    reset = 1'b1;
    exp_q.delete();
    model_rem = 0;
    run_id++;
    @(negedge clock);
    check_output("abort_valid", out_valid, 0);
    check_output("abort_busy", busy, 0);
    check_output("abort_req", req_block, 0);
    check_output("abort_done", done, 0);
    @(negedge clock);
    check_output("abort_no_done", done, 0);
    reset = 1'b0;

    for (int r = 0; r < 6; r++)
      run_squeeze($urandom_range(1, 400), $urandom_range(0, 2));
  endtask

  initial begin
    apply_stimulus();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
